// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 transmitter types: FSM state encoding and frame geometry.
package ps2_tx_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INHIBIT,
      RTS,
      WAIT_START,
      SEND,
      ACK,
      WAIT_RELEASE,
      DONE,
      ERROR
   } ps2_tx_state_t;

   // Frame after the start bit: 8 data bits, parity, stop.
   localparam int          FRAME_W  = 10;
   localparam logic [3:0]  LAST_BIT = 4'd9;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a falling-edge strobe.
module ps2_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic pin_async_i,
   output logic sync_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= pin_async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out 11 bits
// on device falling edges, then check the device ACK and wait for line release.
module ps2_tx
   import ps2_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES        = 6000,
   parameter int SETUP_CYCLES          = 250,
   parameter int START_TIMEOUT_CYCLES  = 750000,
   parameter int PACKET_TIMEOUT_CYCLES = 100000
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       ps2_clk_async_i,
   input  logic       ps2_data_async_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   localparam int MAX_CYC = max2(max2(INHIBIT_CYCLES, SETUP_CYCLES),
                                 max2(START_TIMEOUT_CYCLES, PACKET_TIMEOUT_CYCLES));
   localparam int TW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

   localparam logic [TW-1:0] LD_INHIBIT = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] LD_SETUP   = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] LD_START   = TW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] LD_PACKET  = TW'(PACKET_TIMEOUT_CYCLES - 1);

   logic clk_sync;
   logic clk_fall;
   logic data_sync;
   logic data_fall_unused;

   ps2_sync_edge #(.RESET_VAL(1'b1)) u_clk_sync (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .pin_async_i (ps2_clk_async_i),
      .sync_o      (clk_sync),
      .fall_o      (clk_fall)
   );

   ps2_sync_edge #(.RESET_VAL(1'b1)) u_data_sync (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .pin_async_i (ps2_data_async_i),
      .sync_o      (data_sync),
      .fall_o      (data_fall_unused)
   );

   ps2_tx_state_t        state_q, state_nxt;
   logic [TW-1:0]        timer_q, timer_nxt;
   logic [3:0]           bit_idx_q, bit_idx_nxt;
   logic [FRAME_W-1:0]   frame_q, frame_nxt;
   logic                 clk_oe_nxt, data_oe_nxt;
   logic                 timer_zero;
   logic                 in_packet;

   assign timer_zero = (timer_q == '0);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         bit_idx_q     <= '0;
         ps2_clk_oe_o  <= 1'b0;
         ps2_data_oe_o <= 1'b0;
         ready_o       <= 1'b1;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         error_o       <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         timer_q       <= timer_nxt;
         bit_idx_q     <= bit_idx_nxt;
         ps2_clk_oe_o  <= clk_oe_nxt;
         ps2_data_oe_o <= data_oe_nxt;
         ready_o       <= (state_nxt == IDLE);
         busy_o        <= (state_nxt != IDLE);
         done_o        <= (state_nxt == DONE);
         error_o       <= (state_nxt == ERROR);
      end
   end

   // Frame bits are pure data, loaded only at acceptance.
   always_ff @(posedge clk_i) begin
      frame_q <= frame_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      bit_idx_nxt = bit_idx_q;
      frame_nxt   = frame_q;
      unique case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_nxt = INHIBIT;
               frame_nxt = {1'b1, ~^data_i, data_i};
            end
         end
         INHIBIT:    if (timer_zero) state_nxt = RTS;
         RTS:        if (timer_zero) state_nxt = WAIT_START;
         WAIT_START: begin
            if (clk_fall) begin
               state_nxt   = SEND;
               bit_idx_nxt = '0;
            end else if (timer_zero) begin
               state_nxt = ERROR;
            end
         end
         SEND: begin
            if (timer_zero) begin
               state_nxt = ERROR;
            end else if (clk_fall) begin
               if (bit_idx_q == LAST_BIT) state_nxt = ACK;
               else                       bit_idx_nxt = bit_idx_q + 4'd1;
            end
         end
         ACK: begin
            if (timer_zero || data_sync) state_nxt = ERROR;
            else                         state_nxt = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (timer_zero)                  state_nxt = ERROR;
            else if (clk_sync && data_sync)  state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         ERROR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      clk_oe_nxt = (state_nxt == INHIBIT) || (state_nxt == RTS);
      unique case (state_nxt)
         RTS, WAIT_START: data_oe_nxt = 1'b1;
         SEND:            data_oe_nxt = ~frame_nxt[bit_idx_nxt];
         default:         data_oe_nxt = 1'b0;
      endcase

      // The packet timeout spans SEND through WAIT_RELEASE, so moves inside
      // that window keep counting instead of reloading.
      in_packet = ((state_q == SEND) || (state_q == ACK)) &&
                  ((state_nxt == ACK) || (state_nxt == WAIT_RELEASE));
      if (state_nxt != state_q && !in_packet) begin
         unique case (state_nxt)
            INHIBIT:    timer_nxt = LD_INHIBIT;
            RTS:        timer_nxt = LD_SETUP;
            WAIT_START: timer_nxt = LD_START;
            SEND:       timer_nxt = LD_PACKET;
            default:    timer_nxt = '0;
         endcase
      end else if (!timer_zero) begin
         timer_nxt = timer_q - 1'b1;
      end else begin
         timer_nxt = timer_q;
      end
   end

endmodule
